// File: rtl/key_hold_pkg.sv
// Shared types and sizing helpers for the key hold detector.
package key_hold_pkg;

    // Detector FSM states; WAIT_REL is only reachable with AUTO_RELEASE_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        QUAL      = 3'd2,
        HELD      = 3'd3,
        DEB_REL   = 3'd4,
        WAIT_REL  = 3'd5
    } state_e;

    // Counter width covering the largest cycle count that is actually in use
    function automatic int unsigned cnt_width(
        input int unsigned deb_cycles,
        input int unsigned hold_cycles,
        input int unsigned max_hold_cycles,
        input bit          use_max_hold
    );
        int unsigned largest;
        largest = (deb_cycles > hold_cycles) ? deb_cycles : hold_cycles;
        if (use_max_hold && (max_hold_cycles > largest)) begin
            largest = max_hold_cycles;
        end
        return (largest > 1) ? $clog2(largest) : 1;
    endfunction

endpackage

// File: rtl/key_hold_detector_sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value.
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q, stage1_d;
    logic [WIDTH-1:0] stage2_q, stage2_d;

    // Shift the asynchronous input through two stages
    always_comb begin
        stage1_d = d;
        stage2_d = stage1_q;
    end

    // Synchroniser registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage1_q <= RST_VAL;
            stage2_q <= RST_VAL;
        end else begin
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/key_hold_detector.sv
// Push-button debouncer and hold qualifier producing hold/release strobes.
// Optional macro AUTO_RELEASE_EN: force a release after MAX_HOLD_CYCLES of hold
// and ignore the key until it is physically released.
module key_hold_detector
    import key_hold_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES     = 12500000,
    parameter int unsigned MAX_HOLD_CYCLES = 250000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic hold_tick,
    output logic release_tick,
    output logic key_state,
    output logic hold_active
);

`ifdef AUTO_RELEASE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    localparam int unsigned CNT_W =
        cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, MAX_HOLD_CYCLES, AUTO_EN);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
`ifdef AUTO_RELEASE_EN
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_HOLD_CYCLES - 1);
`endif

    logic       key_sync;
    logic       pressed_s;

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       key_state_q, key_state_d;
    logic       hold_tick_q, hold_tick_d;
    logic       release_tick_q, release_tick_d;
    logic       hold_active_q, hold_active_d;
`ifdef AUTO_RELEASE_EN
    logic       timed_out_q, timed_out_d;
`endif

    // Bring the raw key into the clock domain; idle (released) level out of reset
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_key_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (key_n),
        .q     (key_sync)
    );

    assign pressed_s = ~key_sync;

    // Next-state, counter and strobe logic; counter restarts on every state change
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        key_state_d    = key_state_q;
        hold_tick_d    = 1'b0;
        release_tick_d = 1'b0;
        hold_active_d  = hold_active_q;
`ifdef AUTO_RELEASE_EN
        timed_out_d    = timed_out_q;
`endif

        case (state_q)
            IDLE: begin
                if (pressed_s) begin
                    state_d = DEB_PRESS;
                    cnt_d   = '0;
                end
            end

            DEB_PRESS: begin
                if (!pressed_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = QUAL;
                    cnt_d       = '0;
                    key_state_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            QUAL: begin
                if (!pressed_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d       = HELD;
                    cnt_d         = '0;
                    hold_tick_d   = 1'b1;
                    hold_active_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            HELD: begin
                if (!pressed_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
`ifdef AUTO_RELEASE_EN
                else if (cnt_q == MAX_LAST) begin
                    state_d        = WAIT_REL;
                    cnt_d          = '0;
                    release_tick_d = 1'b1;
                    hold_active_d  = 1'b0;
                    timed_out_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            DEB_REL: begin
                if (pressed_s) begin
                    cnt_d = '0;
                    if (hold_active_q) begin
                        state_d = HELD;
                    end
`ifdef AUTO_RELEASE_EN
                    else if (timed_out_q) begin
                        state_d = WAIT_REL;
                    end
`endif
                    else begin
                        state_d = QUAL;
                    end
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    key_state_d = 1'b0;
                    if (hold_active_q) begin
                        release_tick_d = 1'b1;
                        hold_active_d  = 1'b0;
                    end
`ifdef AUTO_RELEASE_EN
                    timed_out_d = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef AUTO_RELEASE_EN
            WAIT_REL: begin
                if (!pressed_s) begin
                    state_d = DEB_REL;
                    cnt_d   = '0;
                end
            end
`endif

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            key_state_q    <= 1'b0;
            hold_tick_q    <= 1'b0;
            release_tick_q <= 1'b0;
            hold_active_q  <= 1'b0;
`ifdef AUTO_RELEASE_EN
            timed_out_q    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            key_state_q    <= key_state_d;
            hold_tick_q    <= hold_tick_d;
            release_tick_q <= release_tick_d;
            hold_active_q  <= hold_active_d;
`ifdef AUTO_RELEASE_EN
            timed_out_q    <= timed_out_d;
`endif
        end
    end

    assign hold_tick    = hold_tick_q;
    assign release_tick = release_tick_q;
    assign key_state    = key_state_q;
    assign hold_active  = hold_active_q;

endmodule
